csa_resolver: RTL and testbench
===============================

Name: csa_resolver

Overview:
- Converts the redundant sum/carry pair from the wallace-fold 3:2 carry-save stage into one binary result.
- This is the carry-propagate back end of the wallace tree. It accepts one (sum, carry) pair per transaction on a valid/ready handshake.
- It resolves the pair serially, CHUNK bits per clock, so only a narrow adder is needed.
- It presents the WIDTH-bit result plus carry-out on an output valid/ready handshake.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of CHUNK.
- CHUNK, 8: bits resolved per cycle.
- NCHUNK, WIDTH/CHUNK (derived, 4 at defaults): number of resolve cycles.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- in_valid  in  1: sum/carry pair is valid.
- in_ready  out  1: block can accept a pair.
- in_sum  in  WIDTH: carry-save sum vector.
- in_carry  in  WIDTH: carry-save carry vector, already shifted left by one (bit 0 is 0 from the CSA, but it is added regardless).
- out_valid  out  1: result is valid.
- out_ready  in  1: consumer accepts the result.
- out_result  out  WIDTH: (in_sum + in_carry) mod 2^WIDTH.
- out_cout  out  1: carry out of bit WIDTH-1.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE; chunk index, carry register, operand and result registers all 0.
  - Outputs: in_ready=1, out_valid=0, out_result=0, out_cout=0.
- The FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at edge E0: capture in_sum/in_carry, idx<=0, cy<=0, go to ADD.
- ADD:
  - in_ready=0, out_valid=0.
  - Each edge: {cy, result[idx*CHUNK +: CHUNK]} <= sum_chunk + carry_chunk + cy; idx<=idx+1.
  - Chunk k is written on edge E(k+1).
  - After the chunk NCHUNK-1 edge (E4 at defaults), go to DONE. out_cout <= final cy.
- DONE:
  - out_valid=1; out_result and out_cout stay stable.
  - in_ready=0 (no same-cycle accept).
  - On out_ready=1 at an edge, go to IDLE.
  - out_result and out_cout hold their values until the next transaction overwrites them.
- Latency: out_valid rises NCHUNK edges after the acceptance edge (4 at defaults).
- Throughput: the minimum issue interval is NCHUNK+2 cycles (6 at defaults).
- Arithmetic:
  - Everything is unsigned modulo 2^WIDTH; overflow appears only on out_cout.
  - Bit WIDTH-1 of the CSA already drops its carry, so out_cout reflects only the sum/carry overflow, not the original three-operand overflow.
- Boundary conditions:
  - in_valid while busy is ignored. Upstream must hold the pair until in_ready.
  - out_ready while not in DONE is ignored.
  - Back-pressure: out_ready=0 in DONE holds state indefinitely.
  - Reset mid-ADD or mid-DONE aborts the transaction: out_valid drops at once, and the partial result is discarded and cleared.
  - idx wraps to 0 only through the IDLE capture path; it never exceeds NCHUNK-1.

Decomposition:
- Shared package csa_pkg holds:
  - WIDTH and CHUNK defaults, plus derived NCHUNK and the idx width $clog2(NCHUNK).
  - The state encoding IDLE=2'd0, ADD=2'd1, DONE=2'd2.
- One natural sub-module, csa_chunk_add:
  - Combinational CHUNK-bit adder: chunk_a, chunk_b, cin -> chunk_s, cout.
  - Built as a ripple of the existing fa cell, so the gate library stays uniform.
- The top level holds the FSM, operand/result registers and the handshake logic.

Test Plan:
1. in_sum=0x00000005, in_carry=0x0000000A accepted at E0 -> out_valid high after E4; out_result=0x0000000F, out_cout=0.
2. in_sum=0xFFFFFFFF, in_carry=0x00000002 -> out_result=0x00000001, out_cout=1 (wrap-around).
3. Cross-chunk ripple: in_sum=0x00FFFFFF, in_carry=0x00000001 -> out_result=0x01000000, out_cout=0. Check the carry passes through chunks 0->1->2->3.
4. CSA end-to-end with a=7, b=9, c=11:
   - The 3:2 stage gives sum=0x00000005, carry=0x00000016.
   - Required: out_result=0x0000001B (=27), out_cout=0.
5. Back-pressure:
   - Hold out_ready=0 for 3 cycles in DONE -> out_valid, out_result and out_cout stay stable and in_ready=0.
   - A new in_valid is not taken.
   - Raise out_ready -> IDLE next edge, and the next pair is accepted the following edge.
6. Reset mid-operation:
   - Drive rst_n=0 after chunk 1 of 0xFFFFFFFF+0x1 -> out_valid=0, in_ready=1, out_result=0 immediately.
   - After release, 0x00000003+0x00000004 -> 0x00000007, out_cout=0.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults and state encoding for the carry-save resolver
package csa_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CHUNK  = 8;
    localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;
    localparam int IDX_W      = (DEF_NCHUNK > 1) ? $clog2(DEF_NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/csa_chunk_add.sv
// csa_chunk_add: combinational CHUNK-bit ripple adder built from fa cells
module csa_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk_a,
    input  logic [CHUNK-1:0] chunk_b,
    input  logic             cin,
    output logic [CHUNK-1:0] chunk_s,
    output logic             cout
);
    logic [CHUNK:0] c;
    assign c[0] = cin;
    assign cout = c[CHUNK];
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fa u_fa (.a(chunk_a[i]), .b(chunk_b[i]), .ci(c[i]), .s(chunk_s[i]), .co(c[i+1]));
    end
endmodule

// File: rtl/fa.sv
// fa: single-bit full adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: serial carry-propagate back end resolving sum/carry CHUNK bits per clock
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t             state;
    logic [IW-1:0]      idx;
    logic               cy, cout_q, cc;
    logic [WIDTH-1:0]   sum_q, car_q, res_q;
    logic [CHUNK-1:0]   cs;

    csa_chunk_add #(.CHUNK(CHUNK)) u_add (
        .chunk_a(sum_q[idx*CHUNK +: CHUNK]),
        .chunk_b(car_q[idx*CHUNK +: CHUNK]),
        .cin    (cy),
        .chunk_s(cs),
        .cout   (cc)
    );

    assign in_ready   = state == IDLE;
    assign out_valid  = state == DONE;
    assign out_result = res_q;
    assign out_cout   = cout_q;

    // idx saturates on the last chunk; only the IDLE capture rewinds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cy     <= 1'b0;
            sum_q  <= '0;
            car_q  <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sum_q <= in_sum;
                    car_q <= in_carry;
                    idx   <= '0;
                    cy    <= 1'b0;
                    state <= ADD;
                end
                ADD: begin
                    res_q[idx*CHUNK +: CHUNK] <= cs;
                    cy <= cc;
                    if (idx == IW'(NCHUNK - 1)) begin
                        cout_q <= cc;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: table-driven scoreboard bench for csa_resolver
module tb_csa_resolver;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_sum = 0, in_carry = 0;
    logic        in_ready, out_valid, out_cout;
    logic [31:0] out_result;

    csa_resolver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        logic [31:0] r;
        logic        co;
    } vec_t;

    vec_t        vt[6];
    logic [32:0] sb[$];
    int          tests = 0, fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] c);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_sum = s;
        in_carry = c;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic collect(input string nm);
        int n = 0;
        logic [32:0] e;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd4);
        check({nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_scoreboard: got empty queue want entry", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_result"}, 64'(out_result), 64'(e[31:0]));
            check({nm, "_cout"}, 64'(out_cout), 64'(e[32]));
        end
        if (out_ready) begin
            @(posedge clk);
            #1 check({nm, "_drain"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] s, c;
        vt[0] = '{32'h00000005, 32'h0000000A, 32'h0000000F, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b1};
        vt[2] = '{32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0};
        vt[3] = '{32'h00000005, 32'h00000016, 32'h0000001B, 1'b0};
        vt[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vt[5] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_cout", 64'(out_cout), 64'd0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            sb.push_back({vt[i].co, vt[i].r});
            send(vt[i].s, vt[i].c);
            collect($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            s = $urandom;
            c = $urandom;
            sb.push_back({1'b0, s} + {1'b0, c});
            send(s, c);
            collect($sformatf("rnd%0d", i));
        end

        out_ready = 0;
        sb.push_back({1'b0, 32'h00002345});
        send(32'h00001234, 32'h00001111);
        collect("bp");
        @(negedge clk);
        in_sum = 32'hAAAA0000;
        in_carry = 32'h00005555;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(out_result), 64'h2345);
            check("bp_hold_cout", 64'(out_cout), 64'd0);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk) out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        sb.push_back({1'b0, 32'hAAAA5555});
        @(posedge clk);
        #1 in_valid = 0;
        collect("bp_next");

        send(32'hFFFFFFFF, 32'h00000001);
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_result", 64'(out_result), 64'd0);
        check("abort_cout", 64'(out_cout), 64'd0);
        @(negedge clk) rst_n = 1;
        sb.push_back({1'b0, 32'h00000007});
        send(32'h00000003, 32'h00000004);
        collect("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
